sram_dp_be: RTL and testbench

- Parametrised simple-dual-port synchronous SRAM. It succeeds the single-port sram (clk/addr/data_in/write_en/data_out).
- Provides one write port with byte enables and one independent read port with read-enable, read-valid and configurable read latency.
- A built-in clear state machine zeroes the whole array after reset.
- It is the storage element under the FIFO blocks and any register-file style buffering in the design.

---
 rtl/sram_pkg.sv | 21 ++
 rtl/sram_clr_fsm.sv | 39 +++
 rtl/sram_dp_be.sv | 106 ++++++++++
 tb/tb_sram_dp_be.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and elaboration-time helpers for the byte-enable dual-port SRAM.
package sram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } sram_state_t;

    function automatic int calc_nb(input int width, input int byte_w);
        return width / byte_w;
    endfunction

    function automatic bit width_ok(input int width, input int byte_w);
        return (byte_w > 0) && ((width % byte_w) == 0);
    endfunction

    function automatic bit rd_lat_ok(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

endpackage

// File: rtl/sram_clr_fsm.sv
// Post-reset clear sequencer: walks every address once, holding busy high until done.
module sram_clr_fsm
    import sram_pkg::*;
#(
    parameter int ADDR = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            busy,
    output logic            clr_we,
    output logic [ADDR-1:0] clr_addr
);

    sram_state_t state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            clr_addr <= '0;
            busy     <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    // Last address is cleared on this edge; the array is usable next cycle.
                    if (clr_addr == {ADDR{1'b1}}) begin
                        state <= READY;
                        busy  <= 1'b0;
                    end
                end
                READY:   state <= READY;
                default: state <= CLEAR;
            endcase
        end
    end

    assign clr_we = (state == CLEAR);

endmodule

// File: rtl/sram_dp_be.sv
// Simple-dual-port SRAM with byte-lane writes, pipelined reads and a post-reset clear.
// Define SRAM_BYPASS_EN for write-first same-address read-during-write; default is read-first.
module sram_dp_be
    import sram_pkg::*;
#(
    parameter  int ADDR   = 4,
    parameter  int WIDTH  = 32,
    parameter  int BYTE_W = 8,
    parameter  int RD_LAT = 1,
    localparam int NB     = calc_nb(WIDTH, BYTE_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [ADDR-1:0]  wr_addr,
    input  logic [NB-1:0]    wr_be,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [ADDR-1:0]  rd_addr,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy
);

    localparam int DEPTH = 1 << ADDR;

    if (!width_ok(WIDTH, BYTE_W)) begin : g_bad_width
        $error("sram_dp_be: WIDTH must be a multiple of BYTE_W");
    end
    if (!rd_lat_ok(RD_LAT)) begin : g_bad_lat
        $error("sram_dp_be: RD_LAT must be 1 or 2");
    end

    logic            clr_we;
    logic [ADDR-1:0] clr_addr;

    sram_clr_fsm #(.ADDR(ADDR)) u_clr (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_go;
    logic             rd_go;
    logic [WIDTH-1:0] rd_word;

    assign wr_go = wr_en & ~busy;
    assign rd_go = rd_en & ~busy;

    // Nothing touches the array on a reset edge, so a colliding write is dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we) begin
                mem[clr_addr] <= '0;
            end else if (wr_go) begin
                for (int i = 0; i < NB; i++) begin
                    if (wr_be[i]) mem[wr_addr][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    always_comb begin
        rd_word = mem[rd_addr];
`ifdef SRAM_BYPASS_EN
        if (wr_go && (wr_addr == rd_addr)) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) rd_word[i*BYTE_W +: BYTE_W] = wr_data[i*BYTE_W +: BYTE_W];
            end
        end
`endif
    end

    logic [RD_LAT:1]            vld_pipe;
    logic [RD_LAT:1][WIDTH-1:0] dat_pipe;

    // Data stages only load on a valid beat so rd_data holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe[1] <= 1'b0;
            dat_pipe[1] <= '0;
        end else begin
            vld_pipe[1] <= rd_go;
            if (rd_go) dat_pipe[1] <= rd_word;
        end
    end

    if (RD_LAT == 2) begin : g_stage2
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_pipe[RD_LAT] <= 1'b0;
                dat_pipe[RD_LAT] <= '0;
            end else begin
                vld_pipe[RD_LAT] <= vld_pipe[1];
                if (vld_pipe[1]) dat_pipe[RD_LAT] <= dat_pipe[1];
            end
        end
    end

    assign rd_valid = vld_pipe[RD_LAT];
    assign rd_data  = dat_pipe[RD_LAT];

endmodule

// File: tb/tb_sram_dp_be.sv
// Self-checking bench: RD_LAT=1 and RD_LAT=2 instances share stimulus and a behavioural model.
module tb_sram_dp_be;

    localparam int ADDR  = 4;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [3:0]  rd_addr;

    logic        v1, v2, b1, b2;
    logic [31:0] d1, d2;

    always #5 clk = ~clk;

    sram_dp_be #(.ADDR(ADDR), .WIDTH(32), .BYTE_W(8), .RD_LAT(1)) u1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_valid(v1), .rd_data(d1), .busy(b1)
    );

    sram_dp_be #(.ADDR(ADDR), .WIDTH(32), .BYTE_W(8), .RD_LAT(2)) u2 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_valid(v2), .rd_data(d2), .busy(b2)
    );

    int checks = 0;
    int failures = 0;

    // Behavioural model: memory image, remaining clear cycles, and read results keyed by due edge.
    typedef struct { int due; logic [31:0] d; } rd_t;
    logic [31:0] ref_mem [DEPTH];
    int          clear_left;
    int          edge_no = 0;
    rd_t         q1[$];
    rd_t         q2[$];
    logic [31:0] last1, last2;
    logic        exp_v1, exp_v2, exp_busy;
    logic [31:0] exp_d1, exp_d2;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
        return r;
    endfunction

    task automatic cycle();
        logic [31:0] val;
        if (rst) begin
            clear_left = DEPTH;
            for (int a = 0; a < DEPTH; a++) ref_mem[a] = 32'h0;
            q1.delete();
            q2.delete();
            last1 = 32'h0;
            last2 = 32'h0;
        end else if (clear_left > 0) begin
            clear_left--;
        end else begin
            if (rd_en) begin
                val = ref_mem[rd_addr];
`ifdef SRAM_BYPASS_EN
                if (wr_en && wr_addr == rd_addr) val = merge(val, wr_data, wr_be);
`endif
                q1.push_back('{edge_no, val});
                q2.push_back('{edge_no + 1, val});
            end
            if (wr_en) ref_mem[wr_addr] = merge(ref_mem[wr_addr], wr_data, wr_be);
        end
        @(posedge clk);
        exp_v1 = 1'b0;
        exp_v2 = 1'b0;
        if (q1.size() > 0 && q1[0].due == edge_no) begin
            exp_v1 = 1'b1;
            last1 = q1[0].d;
            void'(q1.pop_front());
        end
        if (q2.size() > 0 && q2[0].due == edge_no) begin
            exp_v2 = 1'b1;
            last2 = q2[0].d;
            void'(q2.pop_front());
        end
        exp_d1 = last1;
        exp_d2 = last2;
        exp_busy = (clear_left > 0);
        edge_no++;
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 0; wr_addr = 0; wr_be = 0; wr_data = 0; rd_en = 0; rd_addr = 0;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
        wr_en = 1; wr_addr = a; wr_be = be; wr_data = d;
        cycle();
        wr_en = 0;
    endtask

    // Issue one read; report the RD_LAT=1 output after edges 1 and 2 and RD_LAT=2 after edge 2.
    task automatic do_read(input logic [3:0] a, output logic o_v1, output logic [31:0] o_d1,
                           output logic o_v1_late, output logic o_v2, output logic [31:0] o_d2);
        rd_en = 1; rd_addr = a;
        cycle();
        rd_en = 0;
        o_v1 = v1; o_d1 = d1;
        cycle();
        o_v1_late = v1; o_v2 = v2; o_d2 = d2;
    endtask

    task automatic pulse_reset();
        rst = 1;
        cycle();
        rst = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        pulse_reset();
        checks++;
        if (b1 !== 1'b1 || b2 !== 1'b1) begin
            failures++;
            $display("FAIL reset_busy: got %b/%b want 1/1", b1, b2);
        end
        checks++;
        if (v1 !== 1'b0 || v2 !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid: got %b/%b want 0/0", v1, v2);
        end
        checks++;
        if (d1 !== 32'h0 || d2 !== 32'h0) begin
            failures++;
            $display("FAIL reset_data: got %h/%h want 0/0", d1, d2);
        end
    endtask

    task automatic test_clear_sweep();
        int n = 0;
        logic ov1, ov1l, ov2;
        logic [31:0] od1, od2;
        int bad = 0;
        while (b1 === 1'b1 && n < 40) begin
            cycle();
            n++;
        end
        checks++;
        if (n != 16 || b2 !== 1'b0) begin
            failures++;
            $display("FAIL clear_busy_len: got %0d cycles want 16 (u2 busy=%b)", n, b2);
        end
        for (int a = 0; a < DEPTH; a++) begin
            do_read(a[3:0], ov1, od1, ov1l, ov2, od2);
            if (ov1 !== 1'b1 || od1 !== 32'h0 || ov2 !== 1'b1 || od2 !== 32'h0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL clear_zero: got %0d bad addresses want 0", bad);
        end
    endtask

    task automatic test_byte_enable();
        logic ov1, ov1l, ov2;
        logic [31:0] od1, od2;
        do_write(4'd3, 4'hF, 32'h01234567);
        do_write(4'd3, 4'b0101, 32'hAABBCCDD);
        do_read(4'd3, ov1, od1, ov1l, ov2, od2);
        checks++;
        if (ov1 !== 1'b1 || od1 !== 32'h01BB45DD) begin
            failures++;
            $display("FAIL be_lat1: got v=%b d=%h want v=1 d=01bb45dd", ov1, od1);
        end
        checks++;
        if (ov1l !== 1'b0) begin
            failures++;
            $display("FAIL be_lat1_pulse: got v=%b want 0 one cycle later", ov1l);
        end
        checks++;
        if (ov2 !== 1'b1 || od2 !== 32'h01BB45DD) begin
            failures++;
            $display("FAIL be_lat2: got v=%b d=%h want v=1 d=01bb45dd", ov2, od2);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  sv1, sv2;
        logic [31:0] sd1 [6];
        logic [31:0] sd2 [6];
        logic [31:0] w;
        for (int a = 0; a < 4; a++) begin
            w = 32'hA0 + a;
            do_write(a[3:0], 4'hF, w);
        end
        for (int k = 0; k < 6; k++) begin
            rd_en = (k < 4);
            rd_addr = k[3:0];
            cycle();
            sv1[k] = v1; sd1[k] = d1;
            sv2[k] = v2; sd2[k] = d2;
        end
        rd_en = 0;
        checks++;
        if (sv2 !== 6'b011110) begin
            failures++;
            $display("FAIL b2b_lat2_valid: got %b want 011110", sv2);
        end
        checks++;
        if (sd2[1] !== 32'hA0 || sd2[2] !== 32'hA1 || sd2[3] !== 32'hA2 || sd2[4] !== 32'hA3) begin
            failures++;
            $display("FAIL b2b_lat2_data: got %h %h %h %h want a0 a1 a2 a3",
                     sd2[1], sd2[2], sd2[3], sd2[4]);
        end
        checks++;
        if (sv1 !== 6'b001111 || sd1[0] !== 32'hA0 || sd1[3] !== 32'hA3) begin
            failures++;
            $display("FAIL b2b_lat1: got v=%b d0=%h d3=%h want v=001111 d0=a0 d3=a3",
                     sv1, sd1[0], sd1[3]);
        end
    endtask

    task automatic test_read_during_write();
        logic ov1, ov1l, ov2;
        logic [31:0] od1, od2, want;
`ifdef SRAM_BYPASS_EN
        want = 32'h11112222;
`else
        want = 32'h11111111;
`endif
        do_write(4'd5, 4'hF, 32'h11111111);
        wr_en = 1; wr_addr = 5; wr_be = 4'b0011; wr_data = 32'h22222222;
        rd_en = 1; rd_addr = 5;
        cycle();
        wr_en = 0; rd_en = 0;
        od1 = d1;
        cycle();
        od2 = d2;
        checks++;
        if (od1 !== want || od2 !== want) begin
            failures++;
            $display("FAIL rdw_same_edge: got %h/%h want %h", od1, od2, want);
        end
        do_read(4'd5, ov1, od1, ov1l, ov2, od2);
        checks++;
        if (od1 !== 32'h11112222 || od2 !== 32'h11112222) begin
            failures++;
            $display("FAIL rdw_later: got %h/%h want 11112222", od1, od2);
        end
    endtask

    task automatic test_busy_gating();
        int n = 0;
        int leaks = 0;
        logic ov1, ov1l, ov2;
        logic [31:0] od1, od2;
        do_write(4'd2, 4'hF, 32'h12345678);
        pulse_reset();
        wr_en = 1; wr_addr = 2; wr_be = 4'hF; wr_data = 32'hDEADBEEF;
        rd_en = 1; rd_addr = 2;
        while (b1 === 1'b1 && n < 40) begin
            cycle();
            n++;
            if (v1 !== 1'b0 || v2 !== 1'b0) leaks++;
        end
        idle_inputs();
        cycle();
        if (v1 !== 1'b0 || v2 !== 1'b0) leaks++;
        checks++;
        if (leaks != 0 || n != 16) begin
            failures++;
            $display("FAIL busy_gate_valid: got %0d valids, %0d busy cycles want 0, 16", leaks, n);
        end
        do_read(4'd2, ov1, od1, ov1l, ov2, od2);
        checks++;
        if (od1 !== 32'h0 || od2 !== 32'h0) begin
            failures++;
            $display("FAIL busy_gate_data: got %h/%h want 0", od1, od2);
        end
    endtask

    task automatic test_reset_mid_read();
        int n = 0;
        int leaks = 0;
        do_write(4'd6, 4'hF, 32'hCAFEF00D);
        rd_en = 1; rd_addr = 6;
        cycle();
        rd_en = 0;
        rst = 1;
        wr_en = 1; wr_addr = 6; wr_be = 4'hF; wr_data = 32'h55555555;
        cycle();
        rst = 0;
        wr_en = 0;
        if (v2 !== 1'b0) leaks++;
        checks++;
        if (b1 !== 1'b1 || b2 !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_busy: got %b/%b want 1/1", b1, b2);
        end
        while (b2 === 1'b1 && n < 40) begin
            cycle();
            n++;
            if (v1 !== 1'b0 || v2 !== 1'b0) leaks++;
        end
        checks++;
        if (leaks != 0) begin
            failures++;
            $display("FAIL rst_mid_flush: got %0d valids want 0", leaks);
        end
        checks++;
        if (n != 16) begin
            failures++;
            $display("FAIL rst_mid_sweep: got %0d busy cycles want 16", n);
        end
    endtask

    task automatic test_random();
        int errs = 0;
        for (int k = 0; k < 600; k++) begin
            rst     = ($urandom_range(0, 149) == 0);
            wr_en   = $urandom_range(0, 1);
            wr_addr = $urandom_range(0, 15);
            wr_be   = $urandom_range(0, 15);
            wr_data = $urandom;
            rd_en   = $urandom_range(0, 1);
            rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
            cycle();
            checks++;
            if (b1 !== exp_busy || b2 !== exp_busy || v1 !== exp_v1 || d1 !== exp_d1 ||
                v2 !== exp_v2 || d2 !== exp_d2) begin
                failures++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random[%0d]: got b=%b/%b v1=%b d1=%h v2=%b d2=%h want b=%b v1=%b d1=%h v2=%b d2=%h",
                             k, b1, b2, v1, d1, v2, d2, exp_busy, exp_v1, exp_d1, exp_v2, exp_d2);
            end
        end
        rst = 0;
        idle_inputs();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_clear_sweep();
        test_byte_enable();
        test_back_to_back();
        test_read_during_write();
        test_busy_gating();
        test_reset_mid_read();
        pulse_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
